// File: rtl/pending_priority_encoder.sv
// Captures request pulses into a pending set and grants one index per accepted cycle.
// Define PENDING_PRIO_RR_EN for round-robin selection; fixed lowest-index priority otherwise.
module pending_priority_encoder #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] y,
  output logic [WIDTH-1:0] pending
);

  // Handshake: y is transferred on a rising edge where out_valid && out_ready;
  // y and out_valid stay frozen while out_valid && !out_ready.
  logic             load;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic [WIDTH-1:0] clr;

  assign load = !out_valid || out_ready;

`ifdef PENDING_PRIO_RR_EN
  logic [IDX_W-1:0] ptr;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= WIDTH) s = s - WIDTH;
    return s;
  endfunction

  // Descending scan so the smallest offset from ptr is the last to assign.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[wrap_idx(int'(ptr), i)]) begin
        found = 1'b1;
        sel   = IDX_W'(wrap_idx(int'(ptr), i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load && found) begin
      ptr <= (sel == IDX_W'(WIDTH - 1)) ? '0 : sel + 1'b1;
    end
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    clr = '0;
    if (load && found) clr[sel] = 1'b1;
  end

  // A fresh request on the granted bit re-sets it: set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      pending <= (pending & ~clr) | (in & {WIDTH{ena}});
      if (load) begin
        out_valid <= found;
        if (found) y <= sel;
      end
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Directed bench for pending_priority_encoder (WIDTH=8 and WIDTH=5 instances) with grant scoreboards.
module tb_pending_priority_encoder;

`ifdef PENDING_PRIO_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] in8;
  logic [4:0] in5;
  logic       out_ready;
  logic       out_valid8;
  logic [2:0] y8;
  logic [7:0] pending8;
  logic       out_valid5;
  logic [2:0] y5;
  logic [4:0] pending5;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp5_q[$];

  pending_priority_encoder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in(in8), .out_ready(out_ready),
    .out_valid(out_valid8), .y(y8), .pending(pending8)
  );

  pending_priority_encoder #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in(in5), .out_ready(out_ready),
    .out_valid(out_valid5), .y(y5), .pending(pending5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, return just after the rising edge
  task automatic cycle(input logic [7:0] i8, input logic e, input logic r);
    in8       = i8;
    ena       = e;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // monitors: a grant is consumed on each edge with valid && ready
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant8: unexpected y=%0d", y8);
      end else begin
        check("grant8", 32'(y8), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && out_valid5 && out_ready) begin
      if (exp5_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant5: unexpected y=%0d", y5);
      end else begin
        check("grant5", 32'(y5), 32'(exp5_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in8 = '0; in5 = '0; out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid8), 32'd0);
    check("rst_y", 32'(y8), 32'd0);
    check("rst_pending", 32'(pending8), 32'd0);
    rst_n = 1'b1;
    cycle(8'h00, 1'b1, 1'b1);

    // two requests in one pulse drain lowest first
    exp_q.push_back(3'd5); exp_q.push_back(3'd7);
    cycle(8'hA0, 1'b1, 1'b1);
    check("capture_a0", 32'(pending8), 32'hA0);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check("drain_valid", 32'(out_valid8), 32'd0);
    check("drain_pending", 32'(pending8), 32'd0);

    // backpressure hold with a re-request on the held index
    cycle(8'h08, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle((i == 1) ? 8'h08 : 8'h00, 1'b1, 1'b0);
      check("hold_y", 32'(y8), 32'd3);
      check("hold_valid", 32'(out_valid8), 32'd1);
    end
    check("hold_pending", 32'(pending8), 32'h08);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check("hold_done", 32'(out_valid8), 32'd0);

    // ena low masks capture but does not stall draining
    for (int i = 0; i < 5; i++) begin
      cycle(8'hFF, 1'b0, 1'b1);
      check("mask_pending", 32'(pending8), 32'd0);
      check("mask_valid", 32'(out_valid8), 32'd0);
    end
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    cycle(8'h06, 1'b1, 1'b1);
    cycle(8'hFF, 1'b0, 1'b1);
    cycle(8'hFF, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    check("ena0_drained", 32'(pending8), 32'd0);

    // top index alone
    exp_q.push_back(3'd7);
    cycle(8'h80, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // asynchronous reset mid-transfer
    cycle(8'hFF, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h01, 1'b1, 1'b0);
    check("pre_rst_pending", 32'(pending8), 32'hFF);
    check("pre_rst_valid", 32'(out_valid8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid8), 32'd0);
    check("async_y", 32'(y8), 32'd0);
    check("async_pending", 32'(pending8), 32'd0);
    #2 rst_n = 1'b1;
    in8 = '0; out_ready = 1'b1;
    @(posedge clk); #1;

    // sustained request on bits 0 and 1
    for (int i = 0; i < 5; i++) exp_q.push_back(RR ? 3'(i % 2) : 3'd0);
    exp_q.push_back(RR ? 3'd1 : 3'd0);
    exp_q.push_back(RR ? 3'd0 : 3'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(8'h03, 1'b1, 1'b1);
      check("sustain_pending", 32'(pending8), 32'h03);
    end
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check("sustain_done", 32'(pending8), 32'd0);

    // non-power-of-2 width: pointer wrap from 5 to 0
    exp5_q.push_back(3'd0); exp5_q.push_back(3'd4); exp5_q.push_back(3'd0);
    in5 = 5'b1_0001;
    cycle(8'h00, 1'b1, 1'b1);
    in5 = '0;
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    in5 = 5'b0_0001;
    cycle(8'h00, 1'b1, 1'b1);
    in5 = '0;
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check("w5_pending", 32'(pending5), 32'd0);
    check("w5_valid", 32'(out_valid5), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp5_q_empty", 32'(exp5_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pending_priority_encoder.md
PENDING_PRIORITY_ENCODER -- requirements
Module: pending_priority_encoder

Interface
REQ-001 Parameter WIDTH, default 8, number of request lines; SHALL be >= 2.
REQ-002 Derived localparam IDX_W = $clog2(WIDTH), index width; SHALL NOT be overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  request capture enable; 0 SHALL mask in.
REQ-006 in  input  WIDTH  request pulses, one bit per source.
REQ-007 out_ready  input  1  consumer accepts y this cycle.
REQ-008 out_valid  output  1  y holds a valid granted index.
REQ-009 y  output  IDX_W  granted source index.
REQ-010 pending  output  WIDTH  registered set of captured, not-yet-granted requests.

Function
REQ-011 Capture SHALL be: pending_next = (pending & ~clr) | (in & {WIDTH{ena}}), where clr is the one-hot bit of the index loaded this cycle, or zero.
REQ-012 Set SHALL win over clear: an in bit asserted in the same cycle its index is loaded leaves that pending bit at 1.
REQ-013 A request on a bit already pending SHALL merge, producing one grant.
REQ-014 Load condition SHALL be (!out_valid | out_ready).
REQ-015 On load with pending != 0: y <= selected index, out_valid <= 1, that bit cleared per REQ-011.
REQ-016 On load with pending == 0: out_valid <= 0; y SHALL retain its last value.
REQ-017 While out_valid & !out_ready: y, out_valid and the selection SHALL be held unchanged; capture continues.
REQ-018 Selection SHALL read the registered pending only, never in directly; latency from in sampled at edge k to out_valid at edge k+1 with an empty output stage.
REQ-019 Fixed-priority selection: lowest set index wins (bit 0 highest).
REQ-020 One grant SHALL be issued per accepted cycle; sustained throughput one index per clock.
REQ-021 ena = 0 SHALL NOT stall draining of already pending requests.

Reset
REQ-022 rst_n low SHALL asynchronously force out_valid = 0, y = 0, pending = 0, round-robin pointer = 0, including mid-transfer.
REQ-023 First capture SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-024 Macro PENDING_PRIO_RR_EN defined: round-robin selection; IDX_W-bit pointer ptr; search begins at ptr ascending with wrap to 0; after a load of index g, ptr <= (g+1) mod WIDTH (wrap correct for non-power-of-2 WIDTH).
REQ-025 Macro undefined: fixed priority per REQ-019; no pointer register is present.

Verification
REQ-026 WIDTH=8, out_ready=1, in=8'b1010_0000 for one cycle -> out_valid high two consecutive cycles with y=5 then y=7, then out_valid=0, pending=0.
REQ-027 in=8'h08, out_ready=0 for 4 cycles -> y=3 held stable, out_valid=1; in=8'h08 pulsed again during the hold -> pending=8'h08; out_ready=1 -> second grant y=3.
REQ-028 ena=0, in=8'hFF for 5 cycles -> pending stays 0, out_valid stays 0.
REQ-029 pending=8'hFF, out_valid=1, rst_n pulsed low between edges -> out_valid, y, pending read 0 immediately.
REQ-030 in=8'h03 every cycle, out_ready=1 -> with PENDING_PRIO_RR_EN y alternates 0,1,0,1; without it y=0 every cycle and pending[1] stays 1.
REQ-031 WIDTH=5, PENDING_PRIO_RR_EN, in=5'b1_0001 once -> y=0 then y=4; then in=5'b0_0001 -> y=0 (pointer wrapped from 5 to 0).
